iter_div: RTL
=============

ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width (legal: 4..64).
REQ-002 The block SHALL have ports:
  clk        in   1       clock, all state updates on rising edge
  rst        in   1       synchronous active-high reset
  start      in   1       request a divide; sampled only when not busy
  is_signed  in   1       1 = DIV (two's complement), 0 = DIVU; sampled with start
  dividend   in   DATA_W  numerator; sampled with start
  divisor    in   DATA_W  denominator; sampled with start
  flush      in   1       abort (exception/eret); overrides everything but rst
  busy       out  1       operation in progress
  done       out  1       one-cycle pulse, results valid
  stall      out  1       combinational PC-hold request to the decoder
  quotient   out  DATA_W  LO result, held until the next done
  remainder  out  DATA_W  HI result, held until the next done
  div_zero   out  1       divisor was zero; updated with done
REQ-003 The clock and reset SHALL be a single clk and a synchronous active-high rst.

Function
REQ-004 The FSM SHALL have states IDLE, RUN, FIX, DONE.
REQ-005 In IDLE or DONE, start=1 and flush=0 SHALL capture operands, store magnitudes (absolute values when is_signed, raw otherwise) plus quotient/remainder sign flags, clear the iteration counter, and go to RUN.
REQ-006 RUN SHALL perform one restoring shift-subtract step per cycle for exactly DATA_W cycles, counter width clog2(DATA_W)+1, then go to FIX.
REQ-007 FIX SHALL apply sign correction, register quotient/remainder/div_zero, and go to DONE.
REQ-008 DONE SHALL assert done for exactly one cycle, then go to IDLE unless a new start is accepted (REQ-005).
REQ-009 Latency: start sampled in cycle 0 SHALL give done=1 in cycle DATA_W+2; busy=1 in cycles 1..DATA_W+1 only.
REQ-010 start while busy SHALL be ignored (no queueing, no effect on operands).
REQ-011 stall SHALL equal busy OR (start AND NOT flush AND state in {IDLE,DONE}); stall SHALL be 0 in the done cycle unless a new start is accepted there.
REQ-012 Signed: quotient negative iff operand signs differ; remainder takes dividend's sign; magnitudes handled as DATA_W-bit unsigned so the most negative value is exact.
REQ-013 Signed MIN / -1 SHALL give quotient=MIN, remainder=0, div_zero=0.
REQ-014 Divisor zero SHALL give quotient all ones, remainder=dividend (original, unsigned view), div_zero=1, at normal latency.
REQ-015 flush=1 in any state SHALL force IDLE next cycle, suppress done, leave quotient/remainder/div_zero unchanged; flush wins over a simultaneous start.
REQ-016 quotient, remainder, div_zero SHALL change only in the FIX cycle edge.

Reset
REQ-017 rst=1 SHALL set state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, div_zero=0 at the next edge, including mid-operation; rst wins over flush and start.
REQ-018 stall SHALL be 0 while rst=1.

Structure
REQ-019 The state enumeration and DATA_W-independent constants SHALL live in the shared CPU package.
REQ-020 One combinational sub-module div_step (one restoring step: partial remainder, quotient bit) SHALL be instantiated once; all state remains in iter_div.

Verification
REQ-021 DATA_W=32, unsigned 100/7 start at cycle 0 -> done in cycle 34 only, quotient=14, remainder=2, busy cycles 1..33.
REQ-022 Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-023 Divisor 0, dividend 0x1234 -> quotient=0xFFFFFFFF, remainder=0x1234, div_zero=1 at cycle 34.
REQ-024 flush at cycle 10 of a divide -> busy=0 from cycle 11, no done, prior results unchanged; flush+start same cycle -> no operation.
REQ-025 New start in done cycle (cycle 34) -> accepted, second done at cycle 68; start at cycle 5 while busy -> ignored.
REQ-026 DATA_W=8, unsigned 200/3 -> done at cycle 10, quotient=66, remainder=2; rst at cycle 4 -> all outputs 0, IDLE.

Source files
------------

// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// width-independent constants.
package iter_div_pkg;

   localparam int unsigned DIV_DATA_W_DEFAULT = 32;
   localparam int unsigned DIV_DATA_W_MIN     = 4;
   localparam int unsigned DIV_DATA_W_MAX     = 64;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } div_state_t;

endpackage

// File: rtl/iter_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module div_step #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_in,
   input  logic              dividend_bit,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_out,
   output logic              q_bit
);

   logic [DATA_W:0]   shifted;
   logic [DATA_W-1:0] diff;

   // rem_in < divisor always holds, so the true difference fits in DATA_W bits
   always_comb begin
      shifted = {rem_in, dividend_bit};
      q_bit   = (shifted >= {1'b0, divisor});
      diff    = shifted[DATA_W-1:0] - divisor;
      rem_out = q_bit ? diff : shifted[DATA_W-1:0];
   end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle restoring divider (DIV/DIVU) with flush and a decoder stall
// request; one quotient bit per cycle on unsigned magnitudes.
module iter_div
   import iter_div_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic              stall,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_zero
);

   localparam int unsigned      CNT_W    = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   div_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] quo_work;
   logic [DATA_W-1:0] rem_work;
   logic [DATA_W-1:0] dvs_mag;
   logic              q_neg;
   logic              r_neg;
   logic              dz;

   logic              accept;
   logic [DATA_W-1:0] dvd_mag_in;
   logic [DATA_W-1:0] dvs_mag_in;
   logic [DATA_W-1:0] q_fixed;
   logic [DATA_W-1:0] r_fixed;
   logic [DATA_W-1:0] step_rem;
   logic              step_q;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem_in       (rem_work),
      .dividend_bit (quo_work[DATA_W-1]),
      .divisor      (dvs_mag),
      .rem_out      (step_rem),
      .q_bit        (step_q)
   );

   // Negating MIN yields MIN, which is its exact magnitude when read unsigned
   always_comb begin
      accept     = start & ~flush & ((state == IDLE) | (state == DONE));
      dvd_mag_in = (is_signed & dividend[DATA_W-1]) ? '0 - dividend : dividend;
      dvs_mag_in = (is_signed & divisor[DATA_W-1])  ? '0 - divisor  : divisor;
      q_fixed    = q_neg ? '0 - quo_work : quo_work;
      r_fixed    = r_neg ? '0 - rem_work : rem_work;
      stall      = ~rst & (busy | accept);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         quo_work  <= '0;
         rem_work  <= '0;
         dvs_mag   <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         dz        <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  quo_work <= dvd_mag_in;
                  rem_work <= '0;
                  dvs_mag  <= dvs_mag_in;
                  q_neg    <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                  r_neg    <= is_signed & dividend[DATA_W-1];
                  dz       <= (divisor == '0);
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               rem_work <= step_rem;
               quo_work <= {quo_work[DATA_W-2:0], step_q};
               cnt      <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) state <= FIX;
            end
            FIX: begin
               // divide-by-zero remainder already equals the original dividend
               quotient  <= dz ? '1 : q_fixed;
               remainder <= r_fixed;
               div_zero  <= dz;
               busy      <= 1'b0;
               done      <= 1'b1;
               state     <= DONE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
